ctrl_pipeline: RTL and testbench

CTRL_PIPELINE -- requirements
Module: ctrl_pipeline

---
 rtl/ctrl_pipeline.sv | 177 +++++++++++++++++
 tb/tb_ctrl_pipeline.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/ctrl_pipeline.sv
// Control-bundle pipeline with load-use hazard detection, external stall and flush.
// Optional CTRL_PIPE_STATS_EN adds saturating stall/bubble cycle counters.
module ctrl_pipeline #(
  parameter int CW     = 10,
  parameter int DEPTH  = 3,
  parameter int RW     = 5,
  parameter int LD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [CW-1:0]         ctrl_in,
  input  logic [RW-1:0]         dst_in,
  input  logic                  wr_in,
  input  logic                  ld_in,
  input  logic [RW-1:0]         rs_id,
  input  logic [RW-1:0]         rt_id,
  input  logic                  flush_in,
  input  logic                  stall_ext,
  output logic [DEPTH*CW-1:0]   ctrl_pipe,
  output logic [DEPTH*RW-1:0]   dst_pipe,
  output logic [DEPTH-1:0]      wr_pipe,
  output logic                  pc_write,
  output logic                  ifid_write,
  output logic                  bubble
`ifdef CTRL_PIPE_STATS_EN
  ,
  output logic [15:0]           stall_cnt,
  output logic [15:0]           bubble_cnt
`endif
);

  typedef enum logic [1:0] {
    MODE_NORMAL = 2'd0,
    MODE_HOLD   = 2'd1,
    MODE_FLUSH  = 2'd2,
    MODE_BUBBLE = 2'd3
  } mode_e;

  logic [DEPTH-1:0][CW-1:0] ctrl_q, ctrl_d;
  logic [DEPTH-1:0][RW-1:0] dst_q, dst_d;
  logic [DEPTH-1:0]         wr_q, wr_d;
  logic [DEPTH-1:0]         ld_q, ld_d;
  logic                     hazard_s;
  mode_e                    mode_s;
  logic                     unused_ld_s;

  // Stages at or beyond LD_LAT keep their load flag only for uniformity.
  assign unused_ld_s = ^ld_q;

  // Load-use hazard: a load in the first LD_LAT stages feeds a source of IF/ID.
  always_comb begin
    hazard_s = 1'b0;
    for (int k = 0; k < LD_LAT; k++) begin
      hazard_s = hazard_s |
                 (ld_q[k] & wr_q[k] & (dst_q[k] != {RW{1'b0}}) &
                  ((dst_q[k] == rs_id) | (dst_q[k] == rt_id)));
    end
  end

  // Select the pipeline action by priority and drive the front-end enables.
  always_comb begin
    mode_s     = MODE_NORMAL;
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    bubble     = 1'b0;
    if (stall_ext) begin
      mode_s     = MODE_HOLD;
      pc_write   = 1'b0;
      ifid_write = 1'b0;
    end else if (flush_in) begin
      mode_s = MODE_FLUSH;
      bubble = 1'b1;
    end else if (hazard_s) begin
      mode_s     = MODE_BUBBLE;
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      bubble     = 1'b1;
    end else begin
      mode_s = MODE_NORMAL;
    end
  end

  // Next stage contents: hold, shift with a zero bundle, or shift with the ID bundle.
  always_comb begin
    ctrl_d = ctrl_q;
    dst_d  = dst_q;
    wr_d   = wr_q;
    ld_d   = ld_q;
    case (mode_s)
      MODE_HOLD: begin
        ctrl_d = ctrl_q;
      end
      MODE_FLUSH, MODE_BUBBLE: begin
        for (int k = 1; k < DEPTH; k++) begin
          ctrl_d[k] = ctrl_q[k-1];
          dst_d[k]  = dst_q[k-1];
          wr_d[k]   = wr_q[k-1];
          ld_d[k]   = ld_q[k-1];
        end
        ctrl_d[0] = {CW{1'b0}};
        dst_d[0]  = {RW{1'b0}};
        wr_d[0]   = 1'b0;
        ld_d[0]   = 1'b0;
      end
      MODE_NORMAL: begin
        for (int k = 1; k < DEPTH; k++) begin
          ctrl_d[k] = ctrl_q[k-1];
          dst_d[k]  = dst_q[k-1];
          wr_d[k]   = wr_q[k-1];
          ld_d[k]   = ld_q[k-1];
        end
        ctrl_d[0] = ctrl_in;
        dst_d[0]  = dst_in;
        wr_d[0]   = wr_in;
        ld_d[0]   = ld_in;
      end
      default: begin
        ctrl_d = ctrl_q;
      end
    endcase
  end

  // Stage registers; whatever leaves the last stage is simply dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_q <= {(DEPTH*CW){1'b0}};
      dst_q  <= {(DEPTH*RW){1'b0}};
      wr_q   <= {DEPTH{1'b0}};
      ld_q   <= {DEPTH{1'b0}};
    end else begin
      ctrl_q <= ctrl_d;
      dst_q  <= dst_d;
      wr_q   <= wr_d;
      ld_q   <= ld_d;
    end
  end

  assign ctrl_pipe = ctrl_q;
  assign dst_pipe  = dst_q;
  assign wr_pipe   = wr_q;

`ifdef CTRL_PIPE_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] bubble_cnt_q, bubble_cnt_d;

  // Saturating event counters.
  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (stall_ext && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if (bubble && (bubble_cnt_q != 16'hFFFF)) begin
      bubble_cnt_d = bubble_cnt_q + 16'd1;
    end else begin
      bubble_cnt_d = bubble_cnt_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q  <= 16'd0;
      bubble_cnt_q <= 16'd0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Directed scoreboard bench for ctrl_pipeline: default instance (A) plus a
// DEPTH=4, LD_LAT=2 instance (B) sharing the same stimulus.
module tb_ctrl_pipeline;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  ctrl_in;
  logic [4:0]  dst_in;
  logic        wr_in, ld_in;
  logic [4:0]  rs_id, rt_id;
  logic        flush_in, stall_ext;

  logic [29:0] ctrl_a;
  logic [14:0] dst_a;
  logic [2:0]  wr_a;
  logic        pc_a, ifid_a, bub_a;
  logic [39:0] ctrl_b;
  logic [19:0] dst_b;
  logic [3:0]  wr_b;
  logic        pc_b, ifid_b, bub_b;
`ifdef CTRL_PIPE_STATS_EN
  logic [15:0] scnt_a, bcnt_a, scnt_b, bcnt_b;
`endif

  int n_vec = 0;
  int n_err = 0;

  logic [2:0][9:0] m_ctrl;
  logic [2:0][4:0] m_dst;
  logic [2:0]      m_wr;
  logic [47:0]     sb_q[$];

  always #5 clk = ~clk;

  ctrl_pipeline u_a (
    .clk(clk), .reset(reset), .ctrl_in(ctrl_in), .dst_in(dst_in), .wr_in(wr_in),
    .ld_in(ld_in), .rs_id(rs_id), .rt_id(rt_id), .flush_in(flush_in),
    .stall_ext(stall_ext), .ctrl_pipe(ctrl_a), .dst_pipe(dst_a), .wr_pipe(wr_a),
    .pc_write(pc_a), .ifid_write(ifid_a), .bubble(bub_a)
`ifdef CTRL_PIPE_STATS_EN
    , .stall_cnt(scnt_a), .bubble_cnt(bcnt_a)
`endif
  );

  ctrl_pipeline #(.CW(10), .DEPTH(4), .RW(5), .LD_LAT(2)) u_b (
    .clk(clk), .reset(reset), .ctrl_in(ctrl_in), .dst_in(dst_in), .wr_in(wr_in),
    .ld_in(ld_in), .rs_id(rs_id), .rt_id(rt_id), .flush_in(flush_in),
    .stall_ext(stall_ext), .ctrl_pipe(ctrl_b), .dst_pipe(dst_b), .wr_pipe(wr_b),
    .pc_write(pc_b), .ifid_write(ifid_b), .bubble(bub_b)
`ifdef CTRL_PIPE_STATS_EN
    , .stall_cnt(scnt_b), .bubble_cnt(bcnt_b)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [9:0] c, input logic [4:0] d, input logic w,
                       input logic l, input logic [4:0] rs, input logic [4:0] rt,
                       input logic fl, input logic st);
    ctrl_in = c; dst_in = d; wr_in = w; ld_in = l;
    rs_id = rs; rt_id = rt; flush_in = fl; stall_ext = st;
  endtask

  // Check zero-latency enables, push the expected stage image, clock, then pop and compare.
  task automatic step(input string tag, input logic epa, input logic eba,
                      input logic epb, input logic ebb);
    logic [47:0] exp_v;
    #1;
    chk({tag, ".pc_a"},   {63'd0, pc_a},   {63'd0, epa});
    chk({tag, ".ifid_a"}, {63'd0, ifid_a}, {63'd0, epa});
    chk({tag, ".bub_a"},  {63'd0, bub_a},  {63'd0, eba});
    chk({tag, ".pc_b"},   {63'd0, pc_b},   {63'd0, epb});
    chk({tag, ".ifid_b"}, {63'd0, ifid_b}, {63'd0, epb});
    chk({tag, ".bub_b"},  {63'd0, bub_b},  {63'd0, ebb});
    if (!stall_ext) begin
      m_ctrl[2] = m_ctrl[1]; m_dst[2] = m_dst[1]; m_wr[2] = m_wr[1];
      m_ctrl[1] = m_ctrl[0]; m_dst[1] = m_dst[0]; m_wr[1] = m_wr[0];
      m_ctrl[0] = eba ? 10'd0 : ctrl_in;
      m_dst[0]  = eba ? 5'd0  : dst_in;
      m_wr[0]   = eba ? 1'b0  : wr_in;
    end
    sb_q.push_back({m_ctrl, m_dst, m_wr});
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      n_vec++; n_err++;
      $display("FAIL %s.sb: observed empty queue expected one entry", tag);
    end else begin
      exp_v = sb_q.pop_front();
      chk({tag, ".pipe_a"}, {16'd0, ctrl_a, dst_a, wr_a}, {16'd0, exp_v});
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, ".ctrl_a"}, {34'd0, ctrl_a}, 64'd0);
    chk({tag, ".dst_a"},  {49'd0, dst_a},  64'd0);
    chk({tag, ".wr_a"},   {61'd0, wr_a},   64'd0);
    chk({tag, ".ctrl_b"}, {24'd0, ctrl_b}, 64'd0);
    chk({tag, ".dst_b"},  {44'd0, dst_b},  64'd0);
    chk({tag, ".wr_b"},   {60'd0, wr_b},   64'd0);
    chk({tag, ".pc_a"},   {63'd0, pc_a},   64'd1);
    chk({tag, ".ifid_a"}, {63'd0, ifid_a}, 64'd1);
    chk({tag, ".bub_a"},  {63'd0, bub_a},  64'd0);
    chk({tag, ".bub_b"},  {63'd0, bub_b},  64'd0);
`ifdef CTRL_PIPE_STATS_EN
    chk({tag, ".scnt_a"}, {48'd0, scnt_a}, 64'd0);
    chk({tag, ".bcnt_a"}, {48'd0, bcnt_a}, 64'd0);
`endif
  endtask

  initial begin
    m_ctrl = '0; m_dst = '0; m_wr = '0;
    reset = 1'b0;
    drive(10'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
    #1;
    chk_reset_state("por");
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Load r8 followed by a dependent rs=8: A bubbles once, B twice.
    drive(10'h155, 5'd8, 1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0); step("ld8",   1'b1, 1'b0, 1'b1, 1'b0);
    drive(10'h0AA, 5'd9, 1'b1, 1'b0, 5'd8, 5'd3, 1'b0, 1'b0); step("dep1",  1'b0, 1'b1, 1'b0, 1'b1);
    step("dep2",  1'b1, 1'b0, 1'b0, 1'b1);
    drive(10'h011, 5'd2, 1'b1, 1'b0, 5'd1, 5'd1, 1'b0, 1'b0); step("rel",   1'b1, 1'b0, 1'b1, 1'b0);
    // Load to r0 and load without write never stall.
    drive(10'h3C3, 5'd0, 1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0); step("ld0",   1'b1, 1'b0, 1'b1, 1'b0);
    drive(10'h001, 5'd4, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0); step("use0",  1'b1, 1'b0, 1'b1, 1'b0);
    drive(10'h002, 5'd5, 1'b0, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0); step("ldnw",  1'b1, 1'b0, 1'b1, 1'b0);
    drive(10'h003, 5'd6, 1'b1, 1'b1, 5'd5, 5'd5, 1'b0, 1'b0); step("usenw", 1'b1, 1'b0, 1'b1, 1'b0);
    // Hazard on r6 together with stall, then with flush only.
    drive(10'h007, 5'd7, 1'b1, 1'b0, 5'd6, 5'd0, 1'b1, 1'b1); step("stall", 1'b0, 1'b0, 1'b0, 1'b0);
    drive(10'h007, 5'd7, 1'b1, 1'b0, 5'd6, 5'd0, 1'b1, 1'b0); step("flush", 1'b1, 1'b1, 1'b1, 1'b1);
    // Load r8, dependent through rt.
    drive(10'h100, 5'd8, 1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0); step("ld8b",  1'b1, 1'b0, 1'b1, 1'b0);
    drive(10'h0F0, 5'd3, 1'b1, 1'b0, 5'd1, 5'd8, 1'b0, 1'b0); step("rt1",   1'b0, 1'b1, 1'b0, 1'b1);
    step("rt2",   1'b1, 1'b0, 1'b0, 1'b1);
    step("rt3",   1'b1, 1'b0, 1'b1, 1'b0);
    // Fill the pipe with all-ones bundles.
    for (int i = 0; i < 3; i++) begin
      drive(10'h3FF, 5'd31, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0); step("fill", 1'b1, 1'b0, 1'b1, 1'b0);
    end
    drive(10'h3FF, 5'd8, 1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0); step("ld8c", 1'b1, 1'b0, 1'b1, 1'b0);

    // Pending hazard, then reset pulse between edges.
    drive(10'h3FF, 5'd9, 1'b1, 1'b0, 5'd8, 5'd0, 1'b0, 1'b0);
    #1;
    chk("pend.bub_a", {63'd0, bub_a}, 64'd1);
    #2;
    reset = 1'b0;
    #1;
    chk_reset_state("rst");
    m_ctrl = '0; m_dst = '0; m_wr = '0;
    #1;
    reset = 1'b1;
    step("postrst", 1'b1, 1'b0, 1'b1, 1'b0);

`ifdef CTRL_PIPE_STATS_EN
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk_reset_state("rst2");
    reset = 1'b1;
    stall_ext = 1'b1;
    repeat (70000) @(posedge clk);
    #1;
    chk("sat.scnt_a", {48'd0, scnt_a}, 64'hFFFF);
    chk("sat.scnt_b", {48'd0, scnt_b}, 64'hFFFF);
    chk("sat.bcnt_a", {48'd0, bcnt_a}, 64'd0);
    stall_ext = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
